// File: rtl/registro_display_pkg.sv
// Shared constants for the display/LED register block: register map,
// control layout and reset value, and the 7-segment glyph table.
package registro_display_pkg;

  // Register map (addr_i)
  localparam logic [1:0] DIR_DATOS      = 2'b00;
  localparam logic [1:0] DIR_LEDS       = 2'b01;
  localparam logic [1:0] DIR_CONTROL    = 2'b10;
  localparam logic [1:0] DIR_RESERVADA  = 2'b11;

  // Control register: upper byte = decimal-point mask, lower byte = digit enable
  typedef struct packed {
    logic [7:0] dp_mask;
    logic [7:0] en_mask;
  } control_t;

  // All digits enabled, no decimal points lit
  localparam logic [31:0] CONTROL_RST = 32'h0000_00FF;

  // Blanked-digit drive levels (everything active-low, so all ones = dark)
  localparam logic [7:0] ANODOS_APAGADOS = 8'hFF;
  localparam logic [6:0] SEG_APAGADO     = 7'h7F;

  // Active-low glyphs, bit6 = g ... bit0 = a, indexed by the hex nibble
  typedef logic [6:0] seg_t;
  localparam seg_t TABLA_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

endpackage

// File: rtl/decodificador_7seg.sv
// Hex nibble to active-low 7-segment pattern (g..a), purely combinational.
module decodificador_7seg
  import registro_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segmentos
);

  // Table lookup of the glyph for the current nibble
  always_comb begin
    segmentos = TABLA_SEG[nibble];
  end

endmodule

// File: rtl/registro_display.sv
// CPU-writable display/LED peripheral: holds eight hex digits, a LED word and
// a control word, and time-multiplexes the digits onto a common-anode
// 8-digit 7-segment display.
module registro_display
  import registro_display_pkg::*;
#(
  parameter int CICLOS_REFRESCO = 100000
)
(
  input  logic        clck_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [15:0] leds_o,
  output logic [7:0]  anodos_o,
  output logic [6:0]  segmentos_o,
  output logic        dp_o
);

  localparam int CNT_W = (CICLOS_REFRESCO > 1) ? $clog2(CICLOS_REFRESCO) : 1;
  localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(CICLOS_REFRESCO - 1);

  logic [31:0]      datos_q;
  logic [15:0]      leds_q;
  control_t         control_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;

  logic [3:0] nibble_p0;
  logic [6:0] seg_dec_p0;
  logic [7:0] anodos_p0;
  logic [6:0] seg_p0;
  logic       dp_p0;

  logic [7:0] anodos_p1;
  logic [6:0] seg_p1;
  logic       dp_p1;

  // CPU register file; reserved address writes fall through untouched
  always_ff @(posedge clck_i or posedge rst_i) begin
    if (rst_i) begin
      datos_q   <= '0;
      leds_q    <= '0;
      control_q <= control_t'(CONTROL_RST[15:0]);
    end else if (we_i) begin
      case (addr_i)
        DIR_DATOS:   datos_q   <= wdata_i;
        DIR_LEDS:    leds_q    <= wdata_i[15:0];
        DIR_CONTROL: control_q <= control_t'(wdata_i[15:0]);
        default:     ;
      endcase
    end
  end

  // Slot timer and digit index; index steps when the slot timer wraps
  always_ff @(posedge clck_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (cnt_q == CNT_FIN) begin
      cnt_q <= '0;
      idx_q <= idx_q + 3'd1;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // ---- p0: select the digit for the current index and decode it ----
  assign nibble_p0 = datos_q[{idx_q, 2'b00} +: 4];

  decodificador_7seg u_deco (
    .nibble    (nibble_p0),
    .segmentos (seg_dec_p0)
  );

  // Drive levels for the current slot; a disabled digit stays fully dark
  always_comb begin
    anodos_p0 = ANODOS_APAGADOS;
    seg_p0    = SEG_APAGADO;
    dp_p0     = 1'b1;
    if (control_q.en_mask[idx_q]) begin
      anodos_p0 = ~(8'h01 << idx_q);
      seg_p0    = seg_dec_p0;
      dp_p0     = ~control_q.dp_mask[idx_q];
    end
  end

  // ---- p1: registered display drive, glitch-free at the pins ----
  always_ff @(posedge clck_i or posedge rst_i) begin
    if (rst_i) begin
      anodos_p1 <= ANODOS_APAGADOS;
      seg_p1    <= SEG_APAGADO;
      dp_p1     <= 1'b1;
    end else begin
      anodos_p1 <= anodos_p0;
      seg_p1    <= seg_p0;
      dp_p1     <= dp_p0;
    end
  end

  assign anodos_o    = anodos_p1;
  assign segmentos_o = seg_p1;
  assign dp_o        = dp_p1;
  assign leds_o      = leds_q;

  // Combinational readback of the addressed register
  always_comb begin
    rdata_o = '0;
    case (addr_i)
      DIR_DATOS:   rdata_o = datos_q;
      DIR_LEDS:    rdata_o = {16'h0000, leds_q};
      DIR_CONTROL: rdata_o = {16'h0000, control_q};
      default:     rdata_o = '0;
    endcase
  end

endmodule
